// File: rtl/adc_bus_pkg.sv
// Register map and scan FSM encoding for the ADC peripheral bus.
// Shared by the scan master, the peripheral and benches.
package adc_bus_pkg;

  localparam logic [5:0] ADDR_DATA    = 6'h04;
  localparam logic [5:0] ADDR_CHANNEL = 6'h08;
  localparam logic [5:0] ADDR_INIT    = 6'h0C;
  localparam logic [5:0] ADDR_LEDS    = 6'h10;
  localparam logic [5:0] ADDR_DONE    = 6'h18;

  localparam logic [7:0] INIT_ON  = 8'h01;
  localparam logic [7:0] INIT_OFF = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CH,
    ST_WR_INIT1,
    ST_WR_INIT0,
    ST_POLL,
    ST_RD_DATA,
    ST_CAPTURE,
    ST_NEXT
  } scan_state_e;

endpackage

// File: rtl/adc_scan_master.sv
// Autonomous scan master: walks enabled ADC channels over the
// cs/rd/wr register bus and emits one strobe per conversion.
module adc_scan_master
  import adc_bus_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int INIT_HOLD = 1,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_start,
  input  logic              cont_mode,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              cs,
  output logic              rd,
  output logic              wr,
  output logic [5:0]        addr,
  output logic [7:0]        d_out,
  input  logic [7:0]        d_in,
  output logic [7:0]        sample_data,
  output logic [1:0]        sample_ch,
  output logic              sample_valid,
  output logic              busy,
  output logic              timeout_err
);

  localparam int HW = $clog2(INIT_HOLD + 1);
  localparam int PW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(INIT_HOLD - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(TIMEOUT - 1);

  // {found, index} of the lowest set mask bit at or above 'from'
  function automatic logic [2:0] find_set(
    input logic [NUM_CH-1:0] m,
    input logic [2:0]        from
  );
    logic [2:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  scan_state_e       state_q, state_d;
  logic [1:0]        ch_q, ch_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [PW-1:0]     poll_q, poll_d;
  logic              cs_q, cs_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [5:0]        addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;
  logic [7:0]        sdata_q, sdata_d;
  logic [1:0]        sch_q, sch_d;
  logic              svalid_q, svalid_d;
  logic              busy_q, busy_d;
  logic              terr_q, terr_d;
  logic [2:0]        pick;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    mask_d  = mask_q;
    hold_d  = hold_q;
    poll_d  = poll_q;
    terr_d  = terr_q;
    sdata_d = sdata_q;
    sch_d   = sch_q;
    pick    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (scan_start && (|ch_mask)) begin
          mask_d  = ch_mask;
          pick    = find_set(ch_mask, 3'd0);
          ch_d    = pick[1:0];
          terr_d  = 1'b0;
          state_d = ST_WR_CH;
        end
      end
      ST_WR_CH: begin
        hold_d  = '0;
        state_d = ST_WR_INIT1;
      end
      ST_WR_INIT1: begin
        if (hold_q == HOLD_LAST) state_d = ST_WR_INIT0;
        else hold_d = hold_q + 1'b1;
      end
      ST_WR_INIT0: begin
        poll_d  = '0;
        state_d = ST_POLL;
      end
      ST_POLL: begin
        // first poll cycle sees the previous read, so skip it
        if ((poll_q != '0) && d_in[0]) begin
          state_d = ST_RD_DATA;
        end else if (poll_q == POLL_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_NEXT;
        end else begin
          poll_d = poll_q + 1'b1;
        end
      end
      ST_RD_DATA: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        sdata_d = d_in;
        sch_d   = ch_q;
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        pick = find_set(mask_q, {1'b0, ch_q} + 3'd1);
        if (pick[2]) begin
          ch_d    = pick[1:0];
          state_d = ST_WR_CH;
        end else if (cont_mode) begin
          pick    = find_set(mask_q, 3'd0);
          ch_d    = pick[1:0];
          state_d = ST_WR_CH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // bus outputs are registered from the state being entered
  always_comb begin
    cs_d     = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    addr_d   = '0;
    dout_d   = '0;
    svalid_d = (state_q == ST_CAPTURE);
    busy_d   = (state_d != ST_IDLE);
    unique case (state_d)
      ST_WR_CH: begin
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        addr_d = ADDR_CHANNEL;
        dout_d = {6'b0, ch_d};
      end
      ST_WR_INIT1: begin
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        addr_d = ADDR_INIT;
        dout_d = INIT_ON;
      end
      ST_WR_INIT0: begin
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        addr_d = ADDR_INIT;
        dout_d = INIT_OFF;
      end
      ST_POLL: begin
        cs_d   = 1'b1;
        rd_d   = 1'b1;
        addr_d = ADDR_DONE;
      end
      ST_RD_DATA: begin
        cs_d   = 1'b1;
        rd_d   = 1'b1;
        addr_d = ADDR_DATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      mask_q   <= '0;
      hold_q   <= '0;
      poll_q   <= '0;
      cs_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      sdata_q  <= '0;
      sch_q    <= '0;
      svalid_q <= 1'b0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      mask_q   <= mask_d;
      hold_q   <= hold_d;
      poll_q   <= poll_d;
      cs_q     <= cs_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      sdata_q  <= sdata_d;
      sch_q    <= sch_d;
      svalid_q <= svalid_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
    end
  end

  assign cs           = cs_q;
  assign rd           = rd_q;
  assign wr           = wr_q;
  assign addr         = addr_q;
  assign d_out        = dout_q;
  assign sample_data  = sdata_q;
  assign sample_ch    = sch_q;
  assign sample_valid = svalid_q;
  assign busy         = busy_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_adc_scan_master.sv
// Bench for adc_scan_master: ADC peripheral model plus a
// pass-level reference of expected writes and sample strobes.
module tb_adc_scan_master;
  import adc_bus_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int INIT_HOLD = 2;
  localparam int TIMEOUT   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_start = 1'b0;
  logic       cont_mode = 1'b0;
  logic [3:0] ch_mask = '0;
  logic       cs, rd, wr;
  logic [5:0] addr;
  logic [7:0] d_out;
  logic [7:0] d_in = '0;
  logic [7:0] sample_data;
  logic [1:0] sample_ch;
  logic       sample_valid, busy, timeout_err;

  adc_scan_master #(
    .NUM_CH(NUM_CH), .INIT_HOLD(INIT_HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .scan_start(scan_start),
    .cont_mode(cont_mode), .ch_mask(ch_mask),
    .cs(cs), .rd(rd), .wr(wr), .addr(addr), .d_out(d_out),
    .d_in(d_in), .sample_data(sample_data),
    .sample_ch(sample_ch), .sample_valid(sample_valid),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // peripheral model; pdelay==0 means the conversion never finishes
  logic [7:0] pdata [4];
  int         pdelay [4];
  logic [1:0] p_ch = '0;
  logic       p_init = 1'b0;
  int         p_pend = 0;
  logic       p_done = 1'b0;
  int         cyc = 0;
  int         done_cyc = -100;
  int         poll_reads = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    p_done <= 1'b0;
    if (p_pend > 0) begin
      p_pend <= p_pend - 1;
      p_done <= (p_pend == 1);
    end
    if (cs && wr) begin
      if (addr == ADDR_CHANNEL) p_ch <= d_out[1:0];
      if (addr == ADDR_INIT) begin
        p_init <= d_out[0];
        if (p_init && !d_out[0]) p_pend <= pdelay[p_ch];
      end
    end
    if (cs && rd) begin
      if (addr == ADDR_DONE) begin
        d_in <= {7'b0, p_done};
        if (p_done) done_cyc <= cyc + 1;
      end else if (addr == ADDR_DATA) begin
        d_in <= pdata[p_ch];
      end else begin
        d_in <= 8'h00;
      end
    end
  end

  // observed traffic
  logic [9:0]  strobe_q [$];
  logic [13:0] wr_log [$];
  int strobe_cyc = 0;
  int first_wr_cyc = 0;
  int rd_data_cyc = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (sample_valid) begin
        strobe_q.push_back({sample_ch, sample_data});
        strobe_cyc = cyc;
      end
      if (cs && wr) begin
        if (wr_log.size() == 0) first_wr_cyc = cyc;
        wr_log.push_back({addr, d_out});
        if (addr == ADDR_CHANNEL) poll_reads = 0;
      end
      if (cs && rd && addr == ADDR_DONE) poll_reads++;
      if (cs && rd && addr == ADDR_DATA) rd_data_cyc = cyc;
      check("bus_protocol",
            {31'b0, (rd && wr) || ((rd || wr) && !cs)}, 32'd0);
    end
  end

  // expected traffic
  logic [9:0]  exp_s [$];
  logic [13:0] exp_w [$];
  int start_cyc = 0;
  int idle_cyc = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    strobe_q.delete();
    wr_log.delete();
    exp_s.delete();
    exp_w.delete();
  endtask

  // one pass: each enabled channel in ascending order
  task automatic model_pass(input logic [3:0] m);
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        exp_w.push_back({ADDR_CHANNEL, 8'(c)});
        for (int h = 0; h < INIT_HOLD; h++)
          exp_w.push_back({ADDR_INIT, 8'h01});
        exp_w.push_back({ADDR_INIT, 8'h00});
        if (pdelay[c] != 0) exp_s.push_back({2'(c), pdata[c]});
      end
    end
  endtask

  task automatic start(input logic [3:0] m, input logic c);
    ch_mask = m;
    cont_mode = c;
    scan_start = 1'b1;
    start_cyc = cyc;
    tick();
    scan_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_reached", {31'b0, busy}, 32'd0);
    idle_cyc = cyc;
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_nstrobe"}, strobe_q.size(), exp_s.size());
    for (int i = 0; i < exp_s.size() && i < strobe_q.size(); i++)
      check({tag, "_strobe"}, {22'b0, strobe_q[i]}, {22'b0, exp_s[i]});
    check({tag, "_nwrite"}, wr_log.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wr_log.size(); i++)
      check({tag, "_write"}, {18'b0, wr_log[i]}, {18'b0, exp_w[i]});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] m;
    int n;
    for (int i = 0; i < 4; i++) begin
      pdata[i] = '0;
      pdelay[i] = 1;
    end
    tick();
    check("reset_outputs",
          {2'b0, cs, rd, wr, addr, d_out, sample_data, sample_ch,
           sample_valid, busy, timeout_err}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // single pass over ch0 and ch2
    clear_logs();
    pdata[0] = 8'hA5; pdelay[0] = 10;
    pdata[2] = 8'h3C; pdelay[2] = 10;
    model_pass(4'b0101);
    start(4'b0101, 1'b0);
    check("busy_after_start", {31'b0, busy}, 32'd1);
    wait_idle(400);
    compare_logs("single");
    check("start_latency", first_wr_cyc, start_cyc + 1);
    check("busy_drop", idle_cyc, strobe_cyc + 1);

    // randomized passes
    for (int k = 0; k < 4; k++) begin
      clear_logs();
      m = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++) begin
        pdata[c] = 8'($urandom);
        pdelay[c] = $urandom_range(1, 12);
      end
      model_pass(m);
      start(m, 1'b0);
      wait_idle(600);
      compare_logs("random");
      check("random_terr", {31'b0, timeout_err}, 32'd0);
    end

    // stale done bit left over from a data read of 0x01
    clear_logs();
    pdata[1] = 8'h01; pdelay[1] = 4;
    start(4'b0010, 1'b0);
    wait_idle(200);
    clear_logs();
    pdata[1] = 8'h5E; pdelay[1] = 5;
    model_pass(4'b0010);
    start(4'b0010, 1'b0);
    wait_idle(200);
    compare_logs("stale");
    check("stale_rd_data", rd_data_cyc, done_cyc + 1);
    check("stale_valid", strobe_cyc, done_cyc + 3);

    // timeout on ch1
    clear_logs();
    pdata[0] = 8'($urandom); pdelay[0] = 3;
    pdelay[1] = 0;
    model_pass(4'b0011);
    start(4'b0011, 1'b0);
    wait_idle(400);
    compare_logs("timeout");
    check("timeout_err_set", {31'b0, timeout_err}, 32'd1);
    check("timeout_polls", poll_reads, TIMEOUT);
    clear_logs();
    pdelay[0] = 2;
    start(4'b0001, 1'b0);
    check("timeout_err_clr", {31'b0, timeout_err}, 32'd0);
    wait_idle(200);
    check("timeout_err_stay", {31'b0, timeout_err}, 32'd0);

    // continuous mode on ch3, dropped during the fourth pass
    clear_logs();
    pdata[3] = 8'($urandom); pdelay[3] = 2;
    for (int p = 0; p < 4; p++) model_pass(4'b1000);
    start(4'b1000, 1'b1);
    n = 0;
    while (strobe_q.size() < 3 && n < 400) begin
      tick();
      n++;
    end
    check("cont_three", strobe_q.size(), 3);
    tick();
    cont_mode = 1'b0;
    wait_idle(400);
    compare_logs("cont");

    // reset while polling
    clear_logs();
    pdelay[1] = 0;
    start(4'b0010, 1'b0);
    n = 0;
    while (!(cs && rd && addr == ADDR_DONE) && n < 100) begin
      tick();
      n++;
    end
    check("reached_poll", {31'b0, cs && rd && addr == ADDR_DONE},
          32'd1);
    reset = 1'b1;
    tick();
    check("midreset_outputs",
          {2'b0, cs, rd, wr, addr, d_out, sample_data, sample_ch,
           sample_valid, busy, timeout_err}, 32'd0);
    reset = 1'b0;
    strobe_q.delete();
    repeat (20) tick();
    check("midreset_nostrobe", strobe_q.size(), 0);
    check("midreset_idle", {31'b0, busy}, 32'd0);

    // empty mask never starts a pass
    ch_mask = 4'b0000;
    scan_start = 1'b1;
    repeat (3) begin
      tick();
      check("empty_mask_busy", {31'b0, busy}, 32'd0);
    end
    scan_start = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_scan_master.md
# adc_scan_master

Autonomous bus initiator for the ADC peripheral's 8-bit register interface (cs/rd/wr/addr). It replaces firmware polling: it selects each enabled channel, pulses the conversion start, watches the done flag every cycle, reads the result and presents it as a one-cycle sample strobe. It sits between the peripheral bus port of the ADC peripheral and any consumer of samples, such as a FIFO, display or UART.

## Interface
- `NUM_CH`, default 4: number of scannable channels (1..4); channel index is 2 bits.
- `INIT_HOLD`, default 1: cycles the init register is held at 1 before being cleared.
- `TIMEOUT`, default 4096: maximum POLL cycles per conversion before abort.
- `clk`, in, 1: system clock; single clock domain.
- `reset`, in, 1: synchronous, active-high.
- `scan_start`, in, 1: level sampled in IDLE; starts a pass.
- `cont_mode`, in, 1: when 1, passes repeat until it is seen 0 at a pass boundary.
- `ch_mask`, in, NUM_CH: enabled channels; captured when a pass starts.
- `cs`, out, 1: peripheral chip select.
- `rd`, out, 1: read strobe.
- `wr`, out, 1: write strobe.
- `addr`, out, 6: register address.
- `d_out`, out, 8: write data to the peripheral's `d_in`.
- `d_in`, in, 8: registered read data from the peripheral's `d_out`. The peripheral updates it one edge after `cs&rd`.
- `sample_data`, out, 8: last captured conversion.
- `sample_ch`, out, 2: channel of `sample_data`.
- `sample_valid`, out, 1: one-cycle strobe for a new sample.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `timeout_err`, out, 1: sticky; a conversion timed out.

## Operation
- Register map, fixed: data 0x04, channel 0x08 (bits [1:0]), init 0x0C (bit 0), done 0x18 (bit 0, a one-cycle pulse that the peripheral does not latch).
- States:
  - IDLE: all bus outputs are 0.
    - With `scan_start=1` and `ch_mask!=0`: capture the mask, select the lowest set bit, go to WR_CH.
    - With `ch_mask==0`: ignore the start and stay in IDLE.
  - WR_CH: `cs=wr=1`, addr 0x08, `d_out={6'b0,ch}`. One cycle.
  - WR_INIT1: addr 0x0C, `d_out=8'h01`, `cs=wr=1`. Lasts INIT_HOLD cycles.
  - WR_INIT0: addr 0x0C, `d_out=8'h00`, `cs=wr=1`. One cycle.
  - POLL: hold `cs=rd=1`, addr 0x18 every cycle.
    - The first POLL cycle's `d_in` is stale and must be ignored.
    - From the second cycle on, `d_in[0]=1` means done; go to RD_DATA.
    - Continuous polling guarantees the done pulse is never missed.
  - RD_DATA: `cs=rd=1`, addr 0x04. One cycle.
  - CAPTURE: bus idle. Register `sample_data<=d_in`, `sample_ch<=ch`, `sample_valid<=1`.
  - NEXT: select the next higher set bit of the captured mask.
    - If there is none, the pass has ended:
      - `cont_mode=1`: restart from the lowest set bit in WR_CH.
      - otherwise: go to IDLE.
- Timeout: the POLL counter reaching TIMEOUT sets `timeout_err` and goes to NEXT with no `sample_valid`. `timeout_err` clears only on reset or on an accepted `scan_start`.
- Changes to `ch_mask` or `scan_start` during a pass are ignored. `cont_mode` is sampled only in NEXT at end of pass.

## Timing
- Reset: next edge gives IDLE and all outputs 0 (`cs`, `rd`, `wr`, `addr`, `d_out`, `sample_*`, `busy`, `timeout_err`). This applies mid-transfer as well; no bus cycle completes after reset.
- Start to first bus write: `scan_start` is seen at edge N; WR_CH drives the bus in cycle N+1.
- The peripheral's init register rises for exactly INIT_HOLD cycles.
- Done seen in cycle k (POLL):
  - k+1: RD_DATA.
  - k+2: CAPTURE, with `d_in` holding the data.
  - k+3: `sample_valid` high for exactly one cycle; `sample_data` holds until the next capture.
- Minimum per-channel period is `INIT_HOLD + 7` cycles: WR_CH 1, WR_INIT1 INIT_HOLD, WR_INIT0 1, POLL at least 2, RD_DATA 1, CAPTURE 1, NEXT 1.
- POLL counter width is clog2(TIMEOUT+1). It resets on POLL entry.
- Never `rd` and `wr` together; `cs` is 1 in every rd/wr cycle.

## Structure
- Shared package/include `adc_bus_pkg`: register address constants (ADDR_DATA, ADDR_CHANNEL, ADDR_INIT, ADDR_LEDS, ADDR_DONE) and the state encoding, reused by the peripheral and bench.
- Single module, no sub-modules. The next-channel search is a small function in the same file.

## Test plan
- Single pass: `mask=4'b0101`, `cont=0`, model done after 10 polls, data 0xA5 then 0x3C.
  - Required: writes 0x08←0, 0x0C←1, 0x0C←0, then 0x08←2.
  - Two strobes with (ch0, 0xA5) then (ch2, 0x3C).
  - `busy` drops after the second strobe.
- Stale-read guard: the previous data read is 0x01, and the model has no done for 5 cycles.
  - Required: no RD_DATA before the real done.
  - `sample_valid` exactly 3 cycles after the done-bearing `d_in`.
- Timeout: `TIMEOUT=16`, model never signals done on ch1, `mask=4'b0011`.
  - Required: `timeout_err=1`, one strobe only (ch0), then IDLE.
  - Next `scan_start` clears `timeout_err`.
- Continuous: `mask=4'b1000`, `cont=1` for 3 passes, then `cont=0`.
  - Required: 3 strobes for ch3 before the drop, then the in-progress pass completes and the FSM returns to IDLE.
- Reset mid-POLL: assert `reset` for 1 cycle.
  - Required: all outputs 0 at the next edge, no strobe.
  - `mask=0` with `scan_start` keeps `busy=0`.
